// File: rtl/mem_access_master_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_master_pkg
// Shared definitions for the data-side memory initiator:
//   - access size encodings (also the memory's data_width encoding)
//   - memory write/read strobe polarity
//   - initiator FSM state type
//   - request legality helper (size / alignment)
// ---------------------------------------------------------------------------
package mem_access_master_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  // The memory's write strobe is active-low: 0 = write, 1 = read.
  localparam logic MEM_WR = 1'b0;
  localparam logic MEM_RD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // 1 when a request must be rejected: illegal size or misaligned address.
  function automatic logic req_is_illegal(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic illegal;
    illegal = 1'b0;
    case (size)
      SZ_HALF:    illegal = addr_lo[0];
      SZ_WORD:    illegal = (addr_lo != 2'b00);
      SZ_ILLEGAL: illegal = 1'b1;
      default:    illegal = 1'b0;
    endcase
    return illegal;
  endfunction

endpackage

// File: rtl/mem_access_master_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational formatting of a right-aligned word returned by memory into
// the value handed back to the pipeline.
//   i_word     : raw captured bus value (byte in [7:0], half in [15:0])
//   i_size     : SZ_BYTE / SZ_HALF / SZ_WORD
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_data     : extended result (word passes through untouched)
// ---------------------------------------------------------------------------
module load_extend
  import mem_access_master_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic w_byte_fill;
  logic w_half_fill;

  // Fill bit is the sign bit for signed loads, zero for unsigned ones.
  assign w_byte_fill = ~i_unsigned & i_word[7];
  assign w_half_fill = ~i_unsigned & i_word[15];

  always_comb begin
    o_data = i_word;
    case (i_size)
      SZ_BYTE: o_data = {{24{w_byte_fill}}, i_word[7:0]};
      SZ_HALF: o_data = {{16{w_half_fill}}, i_word[15:0]};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_master.sv
// ---------------------------------------------------------------------------
// mem_access_master
// Data-side memory initiator. Accepts one load/store at a time, performs a
// single-cycle ISSUE on the memory data port, captures load data one cycle
// later, and returns a registered one-cycle response. Illegal-size or
// misaligned requests are answered with rsp_err without touching memory.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   i_req_*  / o_req_ready    : pipeline request handshake and payload
//   o_rsp_valid/rdata/err     : registered response pulse
//   o_d_addr/enable/write     : memory data-port control (write is active-low)
//   o_data_width              : access size to memory (req_size encoding)
//   io_data                   : shared bidirectional data bus
// ---------------------------------------------------------------------------
module mem_access_master
  import mem_access_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_d_addr,
  output logic              o_d_enable,
  output logic              o_d_write,
  output logic [1:0]        o_data_width,
  inout  wire  [DATA_W-1:0] io_data
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_we;
  logic                r_unsigned;
  logic [DATA_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]   r_d_addr;
  logic [1:0]          r_data_width;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic                w_illegal;
  logic                w_latch;
  logic                w_drive;
  logic                w_rsp_valid_next;
  logic                w_rsp_err_next;
  logic [DATA_W-1:0]   w_rsp_rdata_next;
  logic [DATA_W-1:0]   w_load_word;

  assign w_illegal = req_is_illegal(i_req_size, i_req_addr[1:0]);

  load_extend u_load_extend (
    .i_word     (io_data),
    .i_size     (r_data_width),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_word)
  );

  always_comb begin
    w_state_next     = r_state;
    w_rsp_valid_next = 1'b0;
    w_rsp_err_next   = 1'b0;
    w_rsp_rdata_next = '0;
    w_latch          = 1'b0;
    o_req_ready      = (r_state == ST_IDLE);
    o_d_enable       = (r_state == ST_ISSUE);
    o_d_write        = MEM_RD;
    w_drive          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (w_illegal) begin
            // Rejected requests answer next cycle and leave the port idle.
            w_rsp_valid_next = 1'b1;
            w_rsp_err_next   = 1'b1;
          end else begin
            w_latch      = 1'b1;
            w_state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        o_d_write = ~r_we;
        w_drive   = r_we;
        if (r_we) begin
          w_rsp_valid_next = 1'b1;
          w_state_next     = ST_IDLE;
        end else begin
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // Memory presents read data this cycle; bus is owned by memory.
        w_rsp_valid_next = 1'b1;
        w_rsp_rdata_next = w_load_word;
        w_state_next     = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_wdata      <= '0;
      r_d_addr     <= '0;
      r_data_width <= SZ_BYTE;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
      // Address/width registers double as the memory-facing outputs, so
      // they only change on a legal accept and otherwise hold.
      if (w_latch) begin
        r_we         <= i_req_we;
        r_unsigned   <= i_req_unsigned;
        r_wdata      <= i_req_wdata;
        r_d_addr     <= i_req_addr;
        r_data_width <= i_req_size;
      end
    end
  end

  // Per-byte tristate drivers; enabled only in the store ISSUE cycle.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_bus_drv
      assign io_data[gi*8 +: 8] = w_drive ? r_wdata[gi*8 +: 8] : 8'bz;
    end
  endgenerate

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_rsp_err    = r_rsp_err;
  assign o_d_addr     = r_d_addr;
  assign o_data_width = r_data_width;

endmodule

// File: tb/tb_mem_access_master.sv
module tb_mem_access_master;
  import mem_access_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] d_addr;
  logic        d_enable;
  logic        d_write;
  logic [1:0]  data_width;
  tri0  [31:0] data;

  logic        mem_drv;
  logic        mem_clr;
  logic [31:0] mem_rdata;
  logic [7:0]  mem     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic [9:0]  ma;

  int checks   = 0;
  int failures = 0;
  int z_viol   = 0;

  always #5 clk = ~clk;

  mem_access_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_d_addr       (d_addr),
    .o_d_enable     (d_enable),
    .o_d_write      (d_write),
    .o_data_width   (data_width),
    .io_data        (data)
  );

  // Memory side: big-endian byte array, right-aligned data, read data on the
  // bus in the cycle after the enable. Unused upper read bits carry noise.
  assign data = mem_drv ? mem_rdata : 32'bz;
  assign ma   = d_addr[9:0];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end
    if (reset) begin
      mem_drv <= 1'b0;
    end else begin
      mem_drv <= 1'b0;
      if (d_enable) begin
        if (d_write == MEM_WR) begin
          case (data_width)
            2'd2: begin
              mem[ma] <= data[31:24]; mem[ma+10'd1] <= data[23:16];
              mem[ma+10'd2] <= data[15:8]; mem[ma+10'd3] <= data[7:0];
            end
            2'd1: begin mem[ma] <= data[15:8]; mem[ma+10'd1] <= data[7:0]; end
            default: mem[ma] <= data[7:0];
          endcase
        end else begin
          mem_drv <= 1'b1;
          case (data_width)
            2'd2: mem_rdata <= {mem[ma], mem[ma+10'd1], mem[ma+10'd2], mem[ma+10'd3]};
            2'd1: mem_rdata <= {16'($urandom()), mem[ma], mem[ma+10'd1]};
            default: mem_rdata <= {24'($urandom()), mem[ma]};
          endcase
        end
      end
    end
  end

  // Bus ownership monitor: undriven bus reads as the pull value (0).
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_drv) begin
        if (data !== mem_rdata) z_viol++;
      end else if (!(d_enable && d_write == MEM_WR)) begin
        if (data !== 32'h0) z_viol++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference load result from the byte image, using plain arithmetic.
  function automatic logic [31:0] ref_load(input int size, input bit uns, input int a);
    longint v;
    v = 0;
    if (size == 0) begin
      v = ref_mem[a];
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = ref_mem[a] * 256 + ref_mem[a+1];
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = ((ref_mem[a] * 256 + ref_mem[a+1]) * 256 + ref_mem[a+2]) * 256 + ref_mem[a+3];
    end
    return 32'(v);
  endfunction

  // Starts and ends at a negedge; leaves req_valid high so a following call
  // is presented in the response cycle (back-to-back).
  task automatic do_req(input bit we, input int size, input bit uns, input int a,
                        input logic [31:0] wd);
    bit          illegal;
    int          exp_lat, n, en_cnt;
    logic [31:0] exp_rdata;
    bit          got;
    illegal = (size == 3) || (size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0);
    exp_lat   = illegal ? 1 : (we ? 2 : 3);
    exp_rdata = (illegal || we) ? 32'h0 : ref_load(size, uns, a);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = 2'(size); req_unsigned = uns;
    req_addr = 32'(a); req_wdata = wd;
    @(posedge clk);
    n = 0; en_cnt = 0; got = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (d_enable) begin
        en_cnt++;
        chk("d_addr", d_addr, 32'(a));
        chk("d_write", 32'(d_write), 32'(!we));
        chk("d_width", 32'(data_width), 32'(size));
        if (we) chk("st_bus", data, wd);
      end
      if (rsp_valid) got = 1;
      else chk("busy_ready", 32'(req_ready), 32'd0);
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("rsp_err", 32'(rsp_err), 32'(illegal));
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("enables", 32'(en_cnt), illegal ? 32'd0 : 32'd1);
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h (exp %h)",
             we, size, uns, a, wd, n, rsp_err, rsp_rdata, exp_rdata);
    if (!illegal && we) begin
      if (size == 2) begin
        ref_mem[a] = wd[31:24]; ref_mem[a+1] = wd[23:16];
        ref_mem[a+2] = wd[15:8]; ref_mem[a+3] = wd[7:0];
      end else if (size == 1) begin
        ref_mem[a] = wd[15:8]; ref_mem[a+1] = wd[7:0];
      end else begin
        ref_mem[a] = wd[7:0];
      end
    end
  endtask

  task automatic idle(input int cycles);
    req_valid = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_d_enable"}, 32'(d_enable), 32'd0);
    chk({tag, "_d_write"}, 32'(d_write), 32'd1);
    chk({tag, "_d_addr"}, d_addr, 32'd0);
    chk({tag, "_width"}, 32'(data_width), 32'd0);
    chk({tag, "_bus"}, data, 32'd0);
  endtask

  initial begin
    int mism;
    reset = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    mem_clr = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Directed: store word then the extension cases
    do_req(1, 2, 0, 'h100, 32'hDEADBEEF);
    idle(1);
    chk("mem_100", {mem[256], mem[257], mem[258], mem[259]}, 32'hDEADBEEF);
    do_req(0, 0, 0, 'h101, 32'h0); idle(1);
    do_req(0, 0, 1, 'h101, 32'h0); idle(1);
    do_req(0, 1, 0, 'h102, 32'h0); idle(1);
    do_req(0, 1, 1, 'h102, 32'h0); idle(1);
    do_req(0, 2, 0, 'h100, 32'h0); idle(1);

    // Rejected requests
    do_req(0, 2, 0, 'h102, 32'h0); idle(1);
    do_req(1, 1, 0, 'h101, 32'h1234); idle(1);
    do_req(1, 3, 0, 'h100, 32'h5555AAAA); idle(1);

    // Back-to-back with req_valid held: store then load
    do_req(1, 1, 0, 'h200, 32'h0000_8001);
    do_req(0, 1, 0, 'h200, 32'h0);
    do_req(0, 0, 1, 'h201, 32'h0);
    idle(2);

    // Randomized traffic, mostly aligned, mixed gaps
    for (int t = 0; t < 300; t++) begin
      int sz, a;
      sz = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a = a & ~1;
        if (sz == 2) a = a & ~3;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(1);

    // Reset while the load is in CAPTURE
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h104; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    chk("mid_issue", 32'(d_enable), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 1'b0;
    @(negedge clk);
    chk("mid_ready", 32'(req_ready), 32'd1);
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    do_req(0, 2, 0, 'h100, 32'h0);
    idle(2);

    chk("bus_owner", 32'(z_viol), 32'd0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
